// File: rtl/segre_pkg.sv
// Shared types for the RV32M execution pipe: opcode encoding, divider states, sizes.
package segre_pkg;

  localparam int WORD_SIZE = 32;
  localparam int REG_SIZE  = 5;
  localparam int M_STAGES  = 5;

  typedef enum logic [2:0] {
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } m_ext_opcode_e;

  typedef enum logic [1:0] {
    DIV_IDLE, DIV_BUSY, DIV_DONE
  } div_state_e;

  function automatic logic is_m_div(input m_ext_opcode_e op);
    return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/segre_m_ext_div.sv
// Iterative restoring divider, one quotient bit per cycle, RISC-V corner cases resolved here.
//   state    | meaning
//   DIV_IDLE | waiting for start_i; magnitudes and result signs latched on start
//   DIV_BUSY | one restoring iteration per cycle, down-counter r_cnt to zero
//   DIV_DONE | signed result presented on result_o with done_o for one cycle
module segre_m_ext_div
  import segre_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic                 rem_i,
  input  logic [WORD_SIZE-1:0] a_i,
  input  logic [WORD_SIZE-1:0] b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [WORD_SIZE-1:0] result_o
);

  localparam int CW = $clog2(DIV_ITERS);

  div_state_e           r_state;
  logic [CW-1:0]        r_cnt;
  logic [WORD_SIZE-1:0] r_quo, r_rem, r_dvs, r_res;
  logic                 r_neg_q, r_neg_r, r_rem_op, r_dbz, r_done;

  logic [WORD_SIZE-1:0] w_abs_a, w_abs_b, w_quo_nxt, w_rem_nxt, w_q_sgn, w_r_sgn, w_final;
  logic [WORD_SIZE:0]   w_sh, w_diff;
  logic                 w_fits;

  assign w_abs_a = (signed_i && a_i[WORD_SIZE-1]) ? -a_i : a_i;
  assign w_abs_b = (signed_i && b_i[WORD_SIZE-1]) ? -b_i : b_i;

  assign w_sh      = {r_rem, r_quo[WORD_SIZE-1]};
  assign w_diff    = w_sh - {1'b0, r_dvs};
  assign w_fits    = !w_diff[WORD_SIZE];
  assign w_rem_nxt = w_fits ? w_diff[WORD_SIZE-1:0] : w_sh[WORD_SIZE-1:0];
  assign w_quo_nxt = {r_quo[WORD_SIZE-2:0], w_fits};

  // Remainder of x/0 falls out as x naturally; only the quotient needs forcing.
  assign w_q_sgn = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_r_sgn = r_neg_r ? -w_rem_nxt : w_rem_nxt;
  assign w_final = r_rem_op ? w_r_sgn : (r_dbz ? '1 : w_q_sgn);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= DIV_IDLE;
      r_cnt    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_res    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_rem_op <= 1'b0;
      r_dbz    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_quo    <= w_abs_a;
            r_dvs    <= w_abs_b;
            r_rem    <= '0;
            r_cnt    <= CW'(DIV_ITERS - 1);
            r_neg_q  <= signed_i && (a_i[WORD_SIZE-1] ^ b_i[WORD_SIZE-1]);
            r_neg_r  <= signed_i && a_i[WORD_SIZE-1];
            r_rem_op <= rem_i;
            r_dbz    <= (b_i == '0);
            r_state  <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          r_quo <= w_quo_nxt;
          r_rem <= w_rem_nxt;
          if (r_cnt == '0) begin
            r_res   <= w_final;
            r_done  <= 1'b1;
            r_state <= DIV_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DIV_DONE: begin
          r_done  <= 1'b0;
          r_state <= DIV_IDLE;
        end
        default: r_state <= DIV_IDLE;
      endcase
    end
  end

  assign busy_o   = (r_state != DIV_IDLE);
  assign done_o   = r_done;
  assign result_o = r_res;

endmodule

// File: rtl/segre_m_ext_pipe.sv
// RV32M execution pipe M1..M5: pipelined sliced multiplier plus an iterative divider
// that injects its result into the M5 slot, with per-stage rd info for hazard detection.
module segre_m_ext_pipe
  import segre_pkg::*;
#(
  parameter int DIV_ITERS = 32,
  parameter int MUL_SLICE = 11
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                valid_m1_i,
  input  m_ext_opcode_e                       m1_opcode_i,
  input  logic                                m1_rf_we_i,
  input  logic [REG_SIZE-1:0]                 m1_rf_waddr_i,
  input  logic [WORD_SIZE-1:0]                m1_rf_src_a_i,
  input  logic [WORD_SIZE-1:0]                m1_rf_src_b_i,
  input  logic                                kill_m1_i,
  output logic                                m_busy_o,
  output logic [M_STAGES-1:0]                 m_stage_valid_o,
  output logic [M_STAGES-1:0][REG_SIZE-1:0]   m_stage_waddr_o,
  output logic                                m5_valid_o,
  output logic                                m5_rf_we_o,
  output logic [REG_SIZE-1:0]                 m5_rf_waddr_o,
  output logic [WORD_SIZE-1:0]                m5_rd_data_o
);

  localparam int OPW = 3 * MUL_SLICE;
  localparam int PW  = 2 * WORD_SIZE;

  logic [M_STAGES-1:0]  r_vld;
  logic                 r_we    [M_STAGES];
  logic [REG_SIZE-1:0]  r_waddr [M_STAGES];
  m_ext_opcode_e        r_op    [M_STAGES-1];
  logic [OPW-1:0]       r_a0, r_a1, r_a2, r_b0;
  logic [OPW-MUL_SLICE-1:0]   r_b1;
  logic [OPW-2*MUL_SLICE-1:0] r_b2;
  logic [PW-1:0]        r_acc2, r_acc3, r_acc4;
  logic [WORD_SIZE-1:0] r_m5_data;
  logic                 r_div_we;
  logic [REG_SIZE-1:0]  r_div_waddr;

  logic                 w_is_div, w_acc, w_acc_mul, w_acc_div, w_a_sgn, w_b_sgn;
  logic                 w_div_busy, w_div_done;
  logic [WORD_SIZE-1:0] w_div_res;
  logic [PW-1:0]        w_pp0, w_pp1, w_pp2;

  function automatic logic [PW-1:0] sx(input logic [OPW-1:0] v);
    return {{(PW-OPW){v[OPW-1]}}, v};
  endfunction

  assign w_is_div  = is_m_div(m1_opcode_i);
  assign w_acc     = valid_m1_i && !kill_m1_i && !w_div_busy;
  assign w_acc_mul = w_acc && !w_is_div;
  assign w_acc_div = w_acc && w_is_div;
  assign w_a_sgn   = (m1_opcode_i != MULHU);
  assign w_b_sgn   = (m1_opcode_i == MUL) || (m1_opcode_i == MULH);

  // Low slices are unsigned digits; only the top slice carries the operand sign.
  assign w_pp0 = sx(r_a0) * {{(PW-MUL_SLICE){1'b0}}, r_b0[MUL_SLICE-1:0]};
  assign w_pp1 = sx(r_a1) * {{(PW-MUL_SLICE){1'b0}}, r_b1[MUL_SLICE-1:0]};
  assign w_pp2 = sx(r_a2) * {{(PW-MUL_SLICE){r_b2[MUL_SLICE-1]}}, r_b2};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld <= '0;
      for (int i = 0; i < M_STAGES; i++) begin
        r_we[i]    <= 1'b0;
        r_waddr[i] <= '0;
      end
      for (int i = 0; i < M_STAGES-1; i++) r_op[i] <= MUL;
      r_a0 <= '0; r_a1 <= '0; r_a2 <= '0;
      r_b0 <= '0; r_b1 <= '0; r_b2 <= '0;
      r_acc2 <= '0; r_acc3 <= '0; r_acc4 <= '0;
      r_m5_data   <= '0;
      r_div_we    <= 1'b0;
      r_div_waddr <= '0;
    end else begin
      r_vld <= {r_vld[M_STAGES-2:0], w_acc_mul};
      if (w_acc_mul) begin
        r_op[0]    <= m1_opcode_i;
        r_we[0]    <= m1_rf_we_i;
        r_waddr[0] <= m1_rf_waddr_i;
        r_a0       <= {w_a_sgn & m1_rf_src_a_i[WORD_SIZE-1], m1_rf_src_a_i};
        r_b0       <= {w_b_sgn & m1_rf_src_b_i[WORD_SIZE-1], m1_rf_src_b_i};
      end
      for (int i = 1; i < M_STAGES; i++) begin
        if (r_vld[i-1]) begin
          r_we[i]    <= r_we[i-1];
          r_waddr[i] <= r_waddr[i-1];
        end
      end
      if (r_vld[0]) begin
        r_op[1] <= r_op[0];
        r_a1    <= r_a0;
        r_b1    <= r_b0[OPW-1:MUL_SLICE];
        r_acc2  <= w_pp0;
      end
      if (r_vld[1]) begin
        r_op[2] <= r_op[1];
        r_a2    <= r_a1;
        r_b2    <= r_b1[OPW-MUL_SLICE-1:MUL_SLICE];
        r_acc3  <= r_acc2 + (w_pp1 << MUL_SLICE);
      end
      if (r_vld[2]) begin
        r_op[3] <= r_op[2];
        r_acc4  <= r_acc3 + (w_pp2 << (2*MUL_SLICE));
      end
      if (r_vld[3]) begin
        r_m5_data <= (r_op[3] == MUL) ? r_acc4[WORD_SIZE-1:0] : r_acc4[PW-1:WORD_SIZE];
      end
      if (w_acc_div) begin
        r_div_we    <= m1_rf_we_i;
        r_div_waddr <= m1_rf_waddr_i;
      end
    end
  end

  segre_m_ext_div #(.DIV_ITERS(DIV_ITERS)) u_div (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (w_acc_div),
    .signed_i ((m1_opcode_i == DIV) || (m1_opcode_i == REM)),
    .rem_i    ((m1_opcode_i == REM) || (m1_opcode_i == REMU)),
    .a_i      (m1_rf_src_a_i),
    .b_i      (m1_rf_src_b_i),
    .busy_o   (w_div_busy),
    .done_o   (w_div_done),
    .result_o (w_div_res)
  );

  assign m_busy_o        = w_div_busy || w_acc_div;
  assign m_stage_valid_o = {r_vld[M_STAGES-1] | w_div_busy, r_vld[M_STAGES-2:0]};

  always_comb begin
    for (int i = 0; i < M_STAGES; i++) begin
      m_stage_waddr_o[i] = r_vld[i] ? r_waddr[i] : '0;
    end
    if (w_div_busy) m_stage_waddr_o[M_STAGES-1] = r_div_waddr;
  end

  // Mul traffic drains before the divider finishes, so the M5 slot is never contended.
  assign m5_valid_o    = r_vld[M_STAGES-1] || w_div_done;
  assign m5_rf_waddr_o = w_div_done ? r_div_waddr : r_waddr[M_STAGES-1];
  assign m5_rd_data_o  = w_div_done ? w_div_res : r_m5_data;
  assign m5_rf_we_o    = m5_valid_o && (w_div_done ? r_div_we : r_we[M_STAGES-1])
                         && (m5_rf_waddr_o != '0);

  a_no_issue_while_busy: assert property (@(posedge clk_i) disable iff (rst_i)
    !(valid_m1_i && !kill_m1_i && w_div_busy));

endmodule

// File: tb/tb_segre_m_ext_pipe.sv
// Scoreboard bench for segre_m_ext_pipe: issue pushes expected M5 results, a negedge monitor checks them.
module tb_segre_m_ext_pipe;
  import segre_pkg::*;

  logic                     clk = 1'b0, rst = 1'b1;
  logic                     valid = 1'b0, we = 1'b0, kill = 1'b0;
  m_ext_opcode_e            op = MUL;
  logic [4:0]               waddr = '0;
  logic [31:0]              a = '0, b = '0;
  logic                     m_busy, m5_valid, m5_we;
  logic [4:0]               stage_valid, m5_waddr;
  logic [4:0][4:0]          stage_waddr;
  logic [31:0]              m5_data;

  segre_m_ext_pipe dut (
    .clk_i(clk), .rst_i(rst), .valid_m1_i(valid), .m1_opcode_i(op), .m1_rf_we_i(we),
    .m1_rf_waddr_i(waddr), .m1_rf_src_a_i(a), .m1_rf_src_b_i(b), .kill_m1_i(kill),
    .m_busy_o(m_busy), .m_stage_valid_o(stage_valid), .m_stage_waddr_o(stage_waddr),
    .m5_valid_o(m5_valid), .m5_rf_we_o(m5_we), .m5_rf_waddr_o(m5_waddr), .m5_rd_data_o(m5_data)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_errors = 0;

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
    logic [4:0]  waddr;
    logic        we;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (m5_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_m5: got data %h rd %0d, required no result (cycle %0d)",
                 m5_data, m5_waddr, cyc);
      end else begin
        e = sb.pop_front();
        chk("m5_cycle", cyc, e.cyc);
        chk("m5_data", m5_data, e.data);
        chk("m5_waddr", {27'd0, m5_waddr}, {27'd0, e.waddr});
        chk("m5_we", {31'd0, m5_we}, {31'd0, e.we});
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_checks++; n_errors++;
      $display("FAIL missing_m5: got no result, required %h at cycle %0d", e.data, e.cyc);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic issue(input m_ext_opcode_e o, input logic [31:0] va, input logic [31:0] vb,
                       input logic [4:0] rd, input logic k, input logic track,
                       input logic [31:0] res);
    logic isdiv;
    isdiv = (o == DIV) || (o == DIVU) || (o == REM) || (o == REMU);
    valid = 1'b1; op = o; a = va; b = vb; waddr = rd; we = 1'b1; kill = k;
    if (!k && track) sb.push_back('{cyc + (isdiv ? 33 : 5), res, rd, (rd != 5'd0)});
    @(negedge clk);
    chk("busy_at_issue", {31'd0, m_busy}, {31'd0, isdiv && !k});
    step();
    valid = 1'b0; kill = 1'b0;
  endtask

  task automatic run_div(input m_ext_opcode_e o, input logic [31:0] va, input logic [31:0] vb,
                         input logic [4:0] rd, input logic [31:0] res);
    issue(o, va, vb, rd, 1'b0, 1'b1, res);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      chk("busy_during_div", {31'd0, m_busy}, 32'd1);
      chk("div_stage_valid4", {31'd0, stage_valid[4]}, 32'd1);
      chk("div_stage_waddr4", {27'd0, stage_waddr[4]}, {27'd0, rd});
      step();
    end
    @(negedge clk);
    chk("busy_after_div", {31'd0, m_busy}, 32'd0);
    step();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m5_valid", {31'd0, m5_valid}, 32'd0);
    chk("rst_busy", {31'd0, m_busy}, 32'd0);
    chk("rst_stage_valid", {27'd0, stage_valid}, 32'd0);
    chk("rst_stage_waddr", {7'd0, stage_waddr}, 32'd0);
    chk("rst_m5_data", m5_data, 32'd0);
    step();
    rst = 1'b0;
    idle(2);

    // Single MUL, then its progress through M1/M2
    issue(MUL, 32'd7, 32'hFFFF_FFFD, 5'd1, 1'b0, 1'b1, 32'hFFFF_FFEB);
    @(negedge clk); chk("mul_stage_m1", {27'd0, stage_valid}, 32'd1);
    chk("mul_waddr_m1", {27'd0, stage_waddr[0]}, 32'd1);
    step();
    @(negedge clk); chk("mul_stage_m2", {27'd0, stage_valid}, 32'd2);
    step();
    idle(6);

    // Back-to-back high-half multiplies
    issue(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0, 1'b1, 32'hFFFF_FFFE);
    issue(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0, 1'b1, 32'h0000_0000);
    issue(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0, 1'b1, 32'hFFFF_FFFF);
    issue(MUL,    32'h0001_2345, 32'h0000_1000, 5'd5, 1'b0, 1'b1, 32'h1234_5000);
    issue(MULH,   32'h8000_0000, 32'h8000_0000, 5'd6, 1'b0, 1'b1, 32'h4000_0000);
    idle(8);

    // Divides including sign handling and corner cases
    run_div(DIV,  32'd100,       32'hFFFF_FFF9, 5'd5,  32'hFFFF_FFF2);
    run_div(REM,  32'd100,       32'hFFFF_FFF9, 5'd6,  32'd2);
    run_div(REM,  32'hFFFF_FF9C, 32'd7,         5'd7,  32'hFFFF_FFFE);
    run_div(DIVU, 32'hFFFF_FFFF, 32'd16,        5'd8,  32'h0FFF_FFFF);
    run_div(DIVU, 32'd1234,      32'd0,         5'd9,  32'hFFFF_FFFF);
    run_div(DIV,  32'hFFFF_FF9C, 32'd0,         5'd10, 32'hFFFF_FFFF);
    run_div(REM,  32'hFFFF_FF9C, 32'd0,         5'd11, 32'hFFFF_FF9C);
    run_div(REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0);
    run_div(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);

    // Killed MUL leaves no trace; MUL to x0 completes without RF write
    issue(MUL, 32'd3, 32'd5, 5'd14, 1'b1, 1'b1, 32'd15);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); chk("kill_stage_valid", {27'd0, stage_valid}, 32'd0);
      step();
    end
    issue(DIV, 32'd9, 32'd3, 5'd15, 1'b1, 1'b1, 32'd3);
    @(negedge clk); chk("kill_div_busy", {31'd0, m_busy}, 32'd0);
    step();
    issue(MUL, 32'd3, 32'd5, 5'd0, 1'b0, 1'b1, 32'd15);
    idle(8);

    // Reset while a MUL sits in M3 and a DIV is running
    issue(MUL, 32'd6, 32'd7, 5'd16, 1'b0, 1'b0, 32'd42);
    issue(DIV, 32'd50, 32'd5, 5'd17, 1'b0, 1'b0, 32'd10);
    @(negedge clk);
    chk("pre_rst_stage_valid", {27'd0, stage_valid}, 32'h12);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_mul_in_m3", {31'd0, stage_valid[2]}, 32'd1);
    step();
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("post_rst_ctl", {24'd0, m_busy, m5_valid, m5_we, stage_valid}, 32'd0);
      chk("post_rst_addr", {2'd0, m5_waddr, stage_waddr}, 32'd0);
      chk("post_rst_data", m5_data, 32'd0);
      step();
    end

    idle(4);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
